// File: rtl/ahb_sim_ctrl_slv_if.sv
// ahb_sim_ctrl_slv_if: AHB-Lite bus bundle for the simulation-control slave.
//   hsel/haddr/htrans/hwrite/hsize/hwdata/hready : master -> slave
//   hreadyout/hresp/hrdata                        : slave -> master
`timescale 1ns/1ps
interface ahb_sim_ctrl_slv_if;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic        hready;
  logic        hreadyout;
  logic        hresp;
  logic [31:0] hrdata;

  modport master (
    output hsel, haddr, htrans, hwrite, hsize, hwdata, hready,
    input  hreadyout, hresp, hrdata
  );

  modport slave (
    input  hsel, haddr, htrans, hwrite, hsize, hwdata, hready,
    output hreadyout, hresp, hrdata
  );
endinterface

// File: rtl/ahb_sim_ctrl_slv.sv
// ahb_sim_ctrl_slv: AHB-Lite simulation-control mailbox.
//   clk, rst          : clock, asynchronous active-high reset
//   bus (slave)       : AHB-Lite slave port (see ahb_sim_ctrl_slv_if)
//   retire            : one pulse per retired CPU instruction
//   chr_vld/chr_data  : character FIFO head, accepted when chr_rdy is high
//   sim_pass/fail/tmo : sticky verdict flags, sim_done = any of them
// Registers (word offsets): 0xFF8 CTRL, 0xFFC CYCLE, 0xFF0 RETIRE.
`timescale 1ns/1ps
module ahb_sim_ctrl_slv #(
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned WDOG_PERIOD = 5000
) (
  input  logic                   clk,
  input  logic                   rst,
  ahb_sim_ctrl_slv_if.slave      bus,
  input  logic                   retire,
  output logic                   chr_vld,
  output logic [7:0]             chr_data,
  input  logic                   chr_rdy,
  output logic                   sim_pass,
  output logic                   sim_fail,
  output logic                   sim_tmo,
  output logic                   sim_done
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned WW = (WDOG_PERIOD > 1) ? $clog2(WDOG_PERIOD) : 1;
  localparam logic [AW:0]    FULL_CNT  = FIFO_DEPTH[AW:0];
  localparam logic [WW-1:0]  WIN_LAST  = WW'(WDOG_PERIOD - 1);
  localparam logic [9:0] OFF_CTRL   = 10'h3FE;
  localparam logic [9:0] OFF_CYCLE  = 10'h3FF;
  localparam logic [9:0] OFF_RETIRE = 10'h3FC;

  typedef enum logic [1:0] {PH_IDLE, PH_READ, PH_WRITE} phase_e;

  phase_e          phase_q, phase_d;
  logic [9:0]      off_q, off_d;
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]     cnt_q, cnt_d;
  logic [31:0]     cyc_q, cyc_d, ret_q, ret_d;
  logic [WW-1:0]   win_q, win_d;
  logic            seen_q, seen_d;
  logic            pass_q, pass_d, fail_q, fail_d, tmo_q, tmo_d;

  logic addr_acc, fifo_full, fifo_empty, pop, push, done;
  logic is_pass, is_fail, ctrl_wr, char_wr, stall, win_last;

  // Only haddr[11:2] and htrans[1] are decoded; hsize is ignored.
  logic unused_bus;
  assign unused_bus = ^{bus.hsize, bus.haddr[31:12], bus.haddr[1:0], bus.htrans[0]};

  always_comb begin
    fifo_empty = (cnt_q == '0);
    fifo_full  = (cnt_q == FULL_CNT);
    done       = pass_q | fail_q | tmo_q;
    pop        = !fifo_empty & chr_rdy;
    addr_acc   = bus.hsel & bus.hready & bus.htrans[1];
    is_pass    = (bus.hwdata == 32'h0000_0FFF) || (bus.hwdata == 32'hFFFF_0000);
    is_fail    = (bus.hwdata == 32'h0000_0EEE) || (bus.hwdata == 32'hEEEE_0000);
    ctrl_wr    = (phase_q == PH_WRITE) && (off_q == OFF_CTRL);
    char_wr    = ctrl_wr & !is_pass & !is_fail;
    // A pop in the same cycle frees a slot, so only a full FIFO with no pop stalls.
    stall      = char_wr & fifo_full & !pop;
    push       = char_wr & !stall;
    win_last   = (win_q == WIN_LAST);

    // Data phase bookkeeping: a stalled write keeps its data phase open.
    phase_d = PH_IDLE;
    off_d   = off_q;
    if (stall) begin
      phase_d = phase_q;
    end else if (addr_acc) begin
      phase_d = bus.hwrite ? PH_WRITE : PH_READ;
      off_d   = bus.haddr[11:2];
    end

    wptr_d = push ? wptr_q + AW'(1) : wptr_q;
    rptr_d = pop  ? rptr_q + AW'(1) : rptr_q;
    cnt_d  = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + (AW+1)'(1);
    else if (pop && !push) cnt_d = cnt_q - (AW+1)'(1);

    // First verdict wins; later pass/fail writes and expiries are ignored.
    pass_d = pass_q;
    fail_d = fail_q;
    tmo_d  = tmo_q;
    if (!done) begin
      if (ctrl_wr && is_pass)               pass_d = 1'b1;
      else if (ctrl_wr && is_fail)          fail_d = 1'b1;
      else if (win_last && !(seen_q | retire)) tmo_d = 1'b1;
    end

    cyc_d = cyc_q;
    if ((phase_q == PH_WRITE) && (off_q == OFF_CYCLE)) cyc_d = '0;
    else if (!done && (cyc_q != '1))                   cyc_d = cyc_q + 32'd1;

    ret_d = ret_q;
    if (retire && !done && (ret_q != '1)) ret_d = ret_q + 32'd1;

    win_d  = win_last ? '0 : win_q + WW'(1);
    seen_d = win_last ? 1'b0 : (seen_q | retire);
  end

  always_comb begin
    bus.hrdata = '0;
    if (phase_q == PH_READ) begin
      case (off_q)
        OFF_CTRL:   bus.hrdata = {27'b0, fifo_full, fifo_empty, tmo_q, fail_q, pass_q};
        OFF_CYCLE:  bus.hrdata = cyc_q;
        OFF_RETIRE: bus.hrdata = ret_q;
        default:    bus.hrdata = '0;
      endcase
    end
    bus.hreadyout = !stall;
    bus.hresp     = 1'b0;
    chr_vld       = !fifo_empty;
    chr_data      = fifo_empty ? '0 : mem_q[rptr_q];
    sim_pass      = pass_q;
    sim_fail      = fail_q;
    sim_tmo       = tmo_q;
    sim_done      = done;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= PH_IDLE;
      off_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      cyc_q   <= '0;
      ret_q   <= '0;
      win_q   <= '0;
      seen_q  <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      phase_q <= phase_d;
      off_q   <= off_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      cyc_q   <= cyc_d;
      ret_q   <= ret_d;
      win_q   <= win_d;
      seen_q  <= seen_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      tmo_q   <= tmo_d;
    end
  end

  // Storage needs no reset: pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= bus.hwdata[7:0];
  end

endmodule

// File: doc/ahb_sim_ctrl_slv.md
Name: ahb_sim_ctrl_slv

Overview:
AHB-Lite responder for the simulation-control mailbox that CPU test programs write to. It sits on the SoC data AHB as a slave decoded by the interconnect (hsel) at the 0x6000F000 window. It decodes the pass/fail/putchar protocol and buffers characters in a FIFO with a valid/ready drain port. It also provides a readable cycle counter, a retired-instruction counter and a no-retire watchdog, so SoC-level runs end in RTL rather than by bench snooping.

Parameters:
FIFO_DEPTH, 8, character FIFO entries; power of two, >= 2.
WDOG_PERIOD, 5000, cycles per watchdog check window.

Ports:
clk  in  1  single clock; all logic rising-edge.
rst  in  1  asynchronous, active-high reset.
hsel  in  1  slave select.
haddr  in  32  address; only [11:2] decoded.
htrans  in  2  AHB transfer type; NONSEQ/SEQ = htrans[1].
hwrite  in  1  1 = write.
hsize  in  3  ignored; all accesses treated as word.
hwdata  in  32  write data, data phase.
hready  in  1  bus-wide ready.
hreadyout  out  1  slave ready.
hresp  out  1  always 0 (OKAY).
hrdata  out  32  read data.
retire  in  1  CPU retire pulse, one per retired instruction.
chr_vld  out  1  FIFO head valid.
chr_data  out  8  FIFO head byte.
chr_rdy  in  1  consumer accepts head when chr_vld & chr_rdy.
sim_pass  out  1  sticky pass flag.
sim_fail  out  1  sticky fail flag.
sim_tmo  out  1  sticky watchdog-timeout flag.
sim_done  out  1  sim_pass | sim_fail | sim_tmo.

Behaviour:
- Reset values: hreadyout=1, hrdata=0, chr_vld=0, chr_data=0, all sim_* flags=0. FIFO is empty. All counters are 0.
- Address phase is accepted when hsel & hready & htrans[1]. The block latches the offset[11:2] and hwrite, and opens a data phase next cycle. Otherwise no data phase follows.
- Register map (word offsets):
  - 0xFF8 CTRL
    - W: data 0x00000FFF or 0xFFFF0000 sets pass.
    - W: data 0x00000EEE or 0xEEEE0000 sets fail.
    - W: any other value pushes hwdata[7:0] into the FIFO.
    - R: {27'b0, fifo_full, fifo_empty, tmo, fail, pass}.
  - 0xFFC CYCLE
    - R: cycle counter.
    - W: any value clears it to 0.
  - 0xFF0 RETIRE
    - R: retire counter. Writes are ignored.
  - Any other offset: reads return 0; writes have no effect. All accesses get an OKAY response.
- Read data: hrdata is combinational from the latched offset during the read data phase, and 0 in all other cycles. Reads have zero wait states.
- Char write to a full FIFO:
  - hreadyout=0 for every data-phase cycle in which the FIFO is full.
  - The push and hreadyout=1 occur in the first cycle the FIFO is not full.
  - A pop in the same cycle counts as freeing space, so no wait state is inserted in that cycle.
  - hwdata must be held stable by the master, per AHB.
- FIFO: synchronous push/pop. Simultaneous push+pop while non-empty keeps the occupancy unchanged. Pointers wrap modulo FIFO_DEPTH. chr_data is the head entry whenever chr_vld=1.
- Verdict priority: the first of pass/fail/tmo to set wins. Once sim_done=1, later pass/fail writes and watchdog expiry are ignored. CTRL char writes still push to the FIFO.
- CYCLE counter:
  - Increments each cycle while sim_done=0.
  - Saturates at 0xFFFFFFFF and freezes when sim_done=1.
  - A write-clear in the same cycle as an increment: the clear wins.
- RETIRE counter: increments on retire while sim_done=0 and saturates at 0xFFFFFFFF.
- Watchdog:
  - Window counter runs 0..WDOG_PERIOD-1 and wraps.
  - A per-window retire count includes a retire arriving in the last cycle of the window.
  - At the last cycle of the window: if the count (including that cycle) is 0 and sim_done=0, set tmo next edge.
  - The per-window count clears at the wrap.
- rst asserted mid-transfer: everything returns to reset values immediately and the FIFO contents are discarded. The pending data phase is dropped, and hreadyout returns to 1.

Test Plan:
- Reset, then read 0xFFC after 10 idle cycles -> hrdata equals elapsed-cycle count ±1 pipeline. A read of 0xFF8 -> 0x00000008 (empty).
- Write 0x48, 0x69 to 0xFF8 with chr_rdy=1 -> chr_vld pulses carrying 0x48 then 0x69, in order, with no wait states.
- Hold chr_rdy=0, write FIFO_DEPTH+1 chars -> FIFO full. The 9th data phase shows hreadyout=0 until chr_rdy=1 for one cycle; then hreadyout=1, the push occurs and the FIFO stays full.
- Write 0xFFFF0000 to 0xFF8 -> sim_pass=1 and sim_done=1 next cycle, CYCLE frozen. A subsequent 0xEEE write leaves sim_fail=0.
- With WDOG_PERIOD=16:
  - retire held 0 from reset -> sim_tmo=1 after the first window ends (cycle 16).
  - A single retire in cycle 15 -> no timeout in that window.
- Write 0x0 to 0xFFC in the same cycle the counter increments -> reads 0 or 1 at the next read, never the old value. Assert rst during a stalled write -> hreadyout=1, FIFO empty, flags 0.
